// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS controller: IR opcode and memory
// handshake in, all datapath selects and enables out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwrite_cond;
  logic [1:0] pcsrc;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal_op;

  // master = the controller, slave = the datapath it steers
  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwrite_cond, pcsrc, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwrite_cond, pcsrc, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing a shared-memory, single-ALU MIPS multicycle datapath.
// Illegal opcodes trap into a sticky HALT state that only reset leaves.
module multicycle_control (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  // fetch_gate/memwr_gate mark the two states whose strobes follow mem_ready
  typedef struct packed {
    logic       pcwrite;
    logic       pcwrite_cond;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
    logic       fetch_gate;
    logic       memwr_gate;
  } ctrl_t;

  function automatic ctrl_t decode_state(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.memread = 1'b1; c.alusrcb = 2'b01; c.fetch_gate = 1'b1; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   begin c.iord = 1'b1; c.memread = 1'b1; end
      S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.memwr_gate = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; c.instr_done = 1'b1; end
      S_BRANCH:  begin
        c.alusrca      = 1'b1;
        c.aluop        = 2'b01;
        c.pcwrite_cond = 1'b1;
        c.pcsrc        = 2'b01;
        c.instr_done   = 1'b1;
      end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  begin c.regwrite = 1'b1; c.instr_done = 1'b1; end
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.instr_done = 1'b1; end
      S_HALT:    c.illegal_op = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        case (bus.opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_HALT;
        endcase
      end
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    ctrl_d = decode_state(state_d);
  end

  // Outputs are registered alongside the state so they always match state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_state(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  logic run;
  assign run = ~reset;

  assign bus.pcwrite      = run & (ctrl_q.pcwrite | (ctrl_q.fetch_gate & bus.mem_ready));
  assign bus.irwrite      = run & ctrl_q.fetch_gate & bus.mem_ready;
  assign bus.pcwrite_cond = run & ctrl_q.pcwrite_cond;
  assign bus.memread      = run & ctrl_q.memread;
  assign bus.memwrite     = run & ctrl_q.memwrite;
  assign bus.regwrite     = run & ctrl_q.regwrite;
  assign bus.instr_done   = run & (ctrl_q.instr_done | (ctrl_q.memwr_gate & bus.mem_ready));
  assign bus.pcsrc        = ctrl_q.pcsrc;
  assign bus.iord         = ctrl_q.iord;
  assign bus.memtoreg     = ctrl_q.memtoreg;
  assign bus.regdst       = ctrl_q.regdst;
  assign bus.alusrca      = ctrl_q.alusrca;
  assign bus.alusrcb      = ctrl_q.alusrcb;
  assign bus.aluop        = ctrl_q.aluop;
  assign bus.illegal_op   = ctrl_q.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction strobe totals and
// latency are predicted from the instruction class and stall counts, then checked on instr_done.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int         cycles;
    int         memread;
    int         memwrite;
    int         regwrite;
    int         irwrite;
    int         pcwrite;
    int         pcond;
    int         iord;
    int         memtoreg;
    int         regdst;
    logic [1:0] pcsrc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic is_legal(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Expected totals for one instruction from the latency table and the role of each op
  function automatic exp_t model(logic [5:0] op, int fs, int ms, int lead);
    exp_t e;
    int   base;
    logic mem;
    mem = (op == OP_LW) || (op == OP_SW);
    case (op)
      OP_LW:   base = 5;
      OP_BEQ:  base = 3;
      OP_J:    base = 3;
      default: base = 4;
    endcase
    e.cycles   = base + fs + lead + (mem ? ms : 0);
    e.memread  = fs + lead + 1 + ((op == OP_LW) ? ms + 1 : 0);
    e.memwrite = (op == OP_SW) ? ms + 1 : 0;
    e.iord     = mem ? ms + 1 : 0;
    e.regwrite = ((op == OP_LW) || (op == OP_RTYPE) || (op == OP_ADDI)) ? 1 : 0;
    e.irwrite  = 1;
    e.pcwrite  = (op == OP_J) ? 2 : 1;
    e.pcond    = (op == OP_BEQ) ? 1 : 0;
    e.memtoreg = (op == OP_LW) ? 1 : 0;
    e.regdst   = (op == OP_RTYPE) ? 1 : 0;
    e.pcsrc    = (op == OP_BEQ) ? 2'b01 : (op == OP_J) ? 2'b10 : 2'b00;
    return e;
  endfunction

  // Phases: 0 fetch (waits), 1 decode, 2 address, 3 memory access (waits), 4 other
  task automatic applyStimulus(input logic [5:0] op, input int fs, input int ms, input int lead);
    int ph[$];
    sb.push_back(model(op, fs, ms, lead));
    ph = '{0, 1};
    if (op == OP_LW)                          ph = '{0, 1, 2, 3, 4};
    else if (op == OP_SW)                     ph = '{0, 1, 2, 3};
    else if (op == OP_RTYPE || op == OP_ADDI) ph = '{0, 1, 4, 4};
    else                                      ph = '{0, 1, 4};
    foreach (ph[i]) begin
      int stalls;
      stalls = (ph[i] == 0) ? fs : (ph[i] == 3) ? ms : 0;
      for (int k = 0; k < stalls; k++) begin
        bus.mem_ready = 1'b0;
        bus.opcode    = rand_op();
        step();
      end
      bus.mem_ready = (ph[i] == 0 || ph[i] == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.opcode    = (ph[i] == 1 || ph[i] == 2) ? op : rand_op();
      step();
    end
  endtask

  // Leaves one post-reset FETCH stall cycle already spent; the next instruction takes lead=1
  task automatic applyIllegal(input logic [5:0] op, input logic defensive);
    bus.mem_ready = 1'b1;
    bus.opcode    = rand_op();
    step();
    bus.opcode = defensive ? OP_LW : op;
    step();
    if (defensive) begin
      bus.opcode = OP_RTYPE;
      step();
    end
    for (int c = 0; c < 12; c++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.opcode    = (c % 2 == 0) ? OP_LW : rand_op();
      @(negedge clk);
      checkOutput("halt_illegal_op", 32'(bus.illegal_op), 32'd1);
      checkOutput("halt_outputs_zero",
                  32'({bus.pcwrite, bus.pcwrite_cond, bus.pcsrc, bus.iord, bus.memread,
                       bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite,
                       bus.alusrca, bus.alusrcb, bus.aluop, bus.instr_done}), 32'd0);
      step();
    end
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    step();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("halt_exit_illegal_op", 32'(bus.illegal_op), 32'd0);
    checkOutput("halt_exit_memread", 32'(bus.memread), 32'd1);
    step();
  endtask

  task automatic resetInMemRead();
    bus.mem_ready = 1'b1;
    bus.opcode    = rand_op();
    step();
    bus.opcode = OP_LW;
    step();
    step();
    bus.mem_ready = 1'b0;
    bus.opcode    = rand_op();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_memrd_regwrite", 32'(bus.regwrite), 32'd0);
    checkOutput("rst_memrd_memread", 32'(bus.memread), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_memrd_fetch_memread", 32'(bus.memread), 32'd1);
    checkOutput("rst_memrd_fetch_iord", 32'(bus.iord), 32'd0);
    checkOutput("rst_memrd_fetch_regwrite", 32'(bus.regwrite), 32'd0);
    checkOutput("rst_memrd_fetch_alusrcb", 32'(bus.alusrcb), 32'd1);
    step();
  endtask

  // Monitor: accumulate per-instruction strobe totals, compare when instr_done fires
  int   cyc, mr, mw, rw, irw, pw, pc, io, mtr, rd;
  exp_t mon_e;

  always @(negedge clk) begin
    if (reset) begin
      {cyc, mr, mw, rw, irw, pw, pc, io, mtr, rd} = '0;
    end else begin
      cyc++;
      mr  += 32'(bus.memread);
      mw  += 32'(bus.memwrite);
      rw  += 32'(bus.regwrite);
      irw += 32'(bus.irwrite);
      pw  += 32'(bus.pcwrite);
      pc  += 32'(bus.pcwrite_cond);
      io  += 32'(bus.iord);
      mtr += 32'(bus.memtoreg & bus.regwrite);
      rd  += 32'(bus.regdst & bus.regwrite);
      if (bus.instr_done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_instr_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("latency", cyc, mon_e.cycles);
          checkOutput("memread_cycles", mr, mon_e.memread);
          checkOutput("memwrite_cycles", mw, mon_e.memwrite);
          checkOutput("regwrite_pulses", rw, mon_e.regwrite);
          checkOutput("irwrite_pulses", irw, mon_e.irwrite);
          checkOutput("pcwrite_pulses", pw, mon_e.pcwrite);
          checkOutput("pcwrite_cond_pulses", pc, mon_e.pcond);
          checkOutput("iord_cycles", io, mon_e.iord);
          checkOutput("memtoreg_writes", mtr, mon_e.memtoreg);
          checkOutput("regdst_writes", rd, mon_e.regdst);
          checkOutput("final_pcsrc", 32'(bus.pcsrc), 32'(mon_e.pcsrc));
        end
        {cyc, mr, mw, rw, irw, pw, pc, io, mtr, rd} = '0;
      end
    end
  end

  logic [5:0] legal_ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

  initial begin
    logic [5:0] bad;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'd0;
    step();
    @(negedge clk);
    checkOutput("reset_memread", 32'(bus.memread), 32'd0);
    checkOutput("reset_irwrite", 32'(bus.irwrite), 32'd0);
    checkOutput("reset_pcwrite", 32'(bus.pcwrite), 32'd0);
    checkOutput("reset_instr_done", 32'(bus.instr_done), 32'd0);
    step();
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("fetch_memread", 32'(bus.memread), 32'd1);
    checkOutput("fetch_alusrcb", 32'(bus.alusrcb), 32'd1);
    checkOutput("fetch_iord", 32'(bus.iord), 32'd0);
    checkOutput("fetch_illegal_op", 32'(bus.illegal_op), 32'd0);
    checkOutput("fetch_stall_irwrite", 32'(bus.irwrite), 32'd0);
    step();
    applyStimulus(OP_LW, 0, 0, 1);
    applyStimulus(OP_LW, 0, 0, 0);
    applyStimulus(OP_RTYPE, 3, 0, 0);
    applyStimulus(OP_SW, 0, 2, 0);
    applyStimulus(OP_BEQ, 0, 0, 0);
    applyStimulus(OP_J, 0, 0, 0);
    applyStimulus(OP_ADDI, 1, 0, 0);

    applyIllegal(6'b111111, 1'b0);
    applyStimulus(OP_LW, 0, 1, 1);
    applyIllegal(6'b111111, 1'b1);
    applyStimulus(OP_SW, 1, 0, 1);
    resetInMemRead();
    applyStimulus(OP_BEQ, 0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    do bad = rand_op(); while (is_legal(bad));
    applyIllegal(bad, 1'b0);
    applyStimulus(OP_J, 0, 0, 1);

    bus.mem_ready = 1'b0;
    repeat (3) step();
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
